// File: rtl/hazard_ctrl_if.sv
// Hazard controller <-> datapath bundle: instruction words in, PC/latch/squash/forward controls out.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [31:0]      inst_X;
  logic [31:0]      inst_W;
  logic             br_taken_X;
  logic             pc_F_sel;
  logic             pc_en;
  logic             x_en;
  logic             w_en;
  logic             kill_X;
  logic             wb_valid;
  logic             fwd_a;
  logic             fwd_b;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output inst_X, inst_W, br_taken_X,
    input  pc_F_sel, pc_en, x_en, w_en, kill_X, wb_valid, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
  modport slave (
    input  inst_X, inst_W, br_taken_X,
    output pc_F_sel, pc_en, x_en, w_en, kill_X, wb_valid, fwd_a, fwd_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// F/X/W hazard controller: branch squash, W->X forwarding, one-cycle load-use stall.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_ctrl #(
  parameter logic [31:0] NOP   = 32'h0000_0013,
  parameter int          CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  typedef enum logic {RUN, LOAD_WAIT} state_t;
  state_t state_q, state_d;
  logic   kill_q;

  logic [6:0] op_x, op_w;
  logic [4:0] rs1_x, rs2_x, rd_w;
  logic       rs1_use, rs2_use, rd_w_vld, is_load_w;
  logic       raw_a, raw_b, stall, pc_sel;

  assign op_x  = hz.inst_X[6:0];
  assign rs1_x = hz.inst_X[19:15];
  assign rs2_x = hz.inst_X[24:20];
  assign op_w  = hz.inst_W[6:0];
  assign rd_w  = hz.inst_W[11:7];

  assign rs1_use   = !(op_x == OP_LUI || op_x == OP_AUIPC || op_x == OP_JAL);
  assign rs2_use   = (op_x == OP_OP) || (op_x == OP_STORE) || (op_x == OP_BRANCH);
  // A squashed slot carries NOP, so it can never look like a producer.
  assign rd_w_vld  = !(op_w == OP_STORE || op_w == OP_BRANCH) && (hz.inst_W != NOP);
  assign is_load_w = (op_w == OP_LOAD);

  assign raw_a = rs1_use && (rs1_x != 5'd0) && rd_w_vld && (rs1_x == rd_w);
  assign raw_b = rs2_use && (rs2_x != 5'd0) && rd_w_vld && (rs2_x == rd_w);

  assign stall  = (state_q == RUN) && !kill_q && is_load_w && (raw_a || raw_b);
  assign pc_sel = hz.br_taken_X && !kill_q && !stall;

  logic unused_x;
  assign unused_x = ^{hz.inst_X[31:25], hz.inst_X[14:12], hz.inst_X[11:7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      kill_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      kill_q  <= pc_sel;
    end
  end

  always_comb begin
    state_d = RUN;
    if (stall) state_d = LOAD_WAIT;
  end

  always_comb begin
    hz.pc_F_sel = pc_sel;
    hz.pc_en    = !stall;
    hz.x_en     = !stall;
    hz.w_en     = !stall;
    hz.wb_valid = !stall;
    hz.fwd_a    = raw_a && !kill_q && !stall;
    hz.fwd_b    = raw_b && !kill_q && !stall;
    hz.kill_X   = kill_q;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             first_q;

  // The reset-forced kill in the first cycle is not a real squash.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
      first_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
      if (state_q == LOAD_WAIT) stall_q <= stall_q + 1'b1;
      if (kill_q && !first_q)   flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks of hazard_ctrl: reset, forwarding, load-use, branch squash, reset mid-stall.
module tb_hazard_ctrl;
  localparam int          CNT_W = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef HAZARD_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  localparam logic [31:0] ADDI_X5_7  = 32'h0070_0293;
  localparam logic [31:0] ADDI_X0_7  = 32'h0070_0013;
  localparam logic [31:0] ADD_X6_55  = 32'h0052_8333;
  localparam logic [31:0] ADD_X6_00  = 32'h0000_0333;
  localparam logic [31:0] LUI_X5_R5  = 32'h0002_82B7;
  localparam logic [31:0] LW_X7      = 32'h0000_A383;
  localparam logic [31:0] SW_X7      = 32'h0071_2223;
  localparam logic [31:0] BEQ_X1_X2  = 32'h0020_8463;
  localparam logic [31:0] LW_X3      = 32'h0000_A183;
  localparam logic [31:0] BNE_X3_X4  = 32'h0041_9463;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
  hazard_ctrl #(.NOP(NOP), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hz(hz));

  always #5 clk = ~clk;

  // {pc_F_sel, pc_en, x_en, w_en, wb_valid, kill_X, fwd_a, fwd_b}
  logic [7:0] obs;
  assign obs = {hz.pc_F_sel, hz.pc_en, hz.x_en, hz.w_en, hz.wb_valid, hz.kill_X, hz.fwd_a, hz.fwd_b};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] x, input logic [31:0] w, input logic br);
    hz.inst_X = x; hz.inst_W = w; hz.br_taken_X = br; #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(NOP, NOP, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (obs !== 8'b0_1111_1_00) begin errors++; $display("FAIL reset_first got %b exp %b", obs, 8'b0_1111_1_00); end
    checks++; if (hz.stall_cnt !== '0 || hz.flush_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", hz.stall_cnt, hz.flush_cnt); end
    tick();
    checks++; if (obs !== 8'b0_1111_0_00) begin errors++; $display("FAIL reset_second got %b exp %b", obs, 8'b0_1111_0_00); end
  endtask

  task automatic test_alu_forward();
    drive(ADD_X6_55, ADDI_X5_7, 1'b0);
    checks++; if (obs !== 8'b0_1111_0_11) begin errors++; $display("FAIL alu_fwd got %b exp %b", obs, 8'b0_1111_0_11); end
    tick(); drive(ADD_X6_00, ADDI_X0_7, 1'b0);
    checks++; if (obs !== 8'b0_1111_0_00) begin errors++; $display("FAIL alu_fwd_x0 got %b exp %b", obs, 8'b0_1111_0_00); end
    tick(); drive(LUI_X5_R5, ADDI_X5_7, 1'b0);
    checks++; if (obs !== 8'b0_1111_0_00) begin errors++; $display("FAIL lui_no_rs1 got %b exp %b", obs, 8'b0_1111_0_00); end
    tick(); drive(ADD_X6_55, LW_X7, 1'b0);
    checks++; if (obs !== 8'b0_1111_0_00) begin errors++; $display("FAIL load_nodep got %b exp %b", obs, 8'b0_1111_0_00); end
    tick(); drive(SW_X7, ADDI_X5_7, 1'b0);
    checks++; if (obs !== 8'b0_1111_0_00) begin errors++; $display("FAIL store_nodep got %b exp %b", obs, 8'b0_1111_0_00); end
  endtask

  task automatic test_load_use();
    tick(); drive(SW_X7, LW_X7, 1'b0);
    checks++; if (obs !== 8'b0_0000_0_00) begin errors++; $display("FAIL lu_stall got %b exp %b", obs, 8'b0_0000_0_00); end
    tick();
    checks++; if (obs !== 8'b0_1111_0_01) begin errors++; $display("FAIL lu_wait got %b exp %b", obs, 8'b0_1111_0_01); end
    tick(); drive(NOP, NOP, 1'b0);
    checks++; if (obs !== 8'b0_1111_0_00) begin errors++; $display("FAIL lu_after got %b exp %b", obs, 8'b0_1111_0_00); end
    checks++; if (hz.stall_cnt !== CNT_W'(PERF)) begin errors++; $display("FAIL lu_stall_cnt got %0d exp %0d", hz.stall_cnt, PERF); end
  endtask

  task automatic test_branch();
    tick(); drive(BEQ_X1_X2, NOP, 1'b1);
    checks++; if (obs !== 8'b1_1111_0_00) begin errors++; $display("FAIL br_taken got %b exp %b", obs, 8'b1_1111_0_00); end
    tick(); drive(ADD_X6_55, ADDI_X5_7, 1'b1);
    checks++; if (obs !== 8'b0_1111_1_00) begin errors++; $display("FAIL br_killed got %b exp %b", obs, 8'b0_1111_1_00); end
    tick(); drive(NOP, NOP, 1'b0);
    checks++; if (obs !== 8'b0_1111_0_00) begin errors++; $display("FAIL br_after got %b exp %b", obs, 8'b0_1111_0_00); end
    checks++; if (hz.flush_cnt !== CNT_W'(PERF)) begin errors++; $display("FAIL br_flush_cnt got %0d exp %0d", hz.flush_cnt, PERF); end
  endtask

  task automatic test_branch_on_load();
    tick(); drive(BNE_X3_X4, LW_X3, 1'b1);
    checks++; if (obs !== 8'b0_0000_0_00) begin errors++; $display("FAIL bl_stall got %b exp %b", obs, 8'b0_0000_0_00); end
    tick();
    checks++; if (obs !== 8'b1_1111_0_10) begin errors++; $display("FAIL bl_wait got %b exp %b", obs, 8'b1_1111_0_10); end
    tick(); drive(NOP, NOP, 1'b0);
    checks++; if (obs !== 8'b0_1111_1_00) begin errors++; $display("FAIL bl_killed got %b exp %b", obs, 8'b0_1111_1_00); end
    tick();
    checks++; if (hz.stall_cnt !== CNT_W'(2*PERF) || hz.flush_cnt !== CNT_W'(2*PERF)) begin
      errors++; $display("FAIL bl_cnt got %0d/%0d exp %0d/%0d", hz.stall_cnt, hz.flush_cnt, 2*PERF, 2*PERF);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(SW_X7, LW_X7, 1'b0);
    checks++; if (obs !== 8'b0_0000_0_00) begin errors++; $display("FAIL rms_stall got %b exp %b", obs, 8'b0_0000_0_00); end
    tick();
    checks++; if (obs !== 8'b0_1111_0_01) begin errors++; $display("FAIL rms_wait got %b exp %b", obs, 8'b0_1111_0_01); end
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    checks++; if (obs !== 8'b0_1111_1_00) begin errors++; $display("FAIL rms_reset got %b exp %b", obs, 8'b0_1111_1_00); end
    checks++; if (hz.stall_cnt !== '0 || hz.flush_cnt !== '0) begin errors++; $display("FAIL rms_cnt got %0d/%0d exp 0/0", hz.stall_cnt, hz.flush_cnt); end
    tick();
    checks++; if (obs !== 8'b0_0000_0_00) begin errors++; $display("FAIL rms_restall got %b exp %b", obs, 8'b0_0000_0_00); end
    tick(); tick(); drive(NOP, NOP, 1'b0);
    checks++; if (hz.stall_cnt !== CNT_W'(PERF) || hz.flush_cnt !== '0) begin
      errors++; $display("FAIL rms_cnt2 got %0d/%0d exp %0d/0", hz.stall_cnt, hz.flush_cnt, PERF);
    end
  endtask

  initial begin
    hz.inst_X = NOP; hz.inst_W = NOP; hz.br_taken_X = 1'b0;
    test_reset();
    test_alu_forward();
    test_load_use();
    test_branch();
    test_branch_on_load();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the three-stage Fetch/Execute/Write-back RISC-V core. It sits beside `Control_F`, `Control_X` and `Control_W`, and it owns four datapath decisions:
- the PC source;
- the pipeline-latch enables;
- squashing of wrong-path instructions;
- operand forwarding from W into X.

It resolves taken branches/jumps, RAW hazards against the instruction in W, and the one-cycle load-data latency of the synchronous-read DMEM.

## Interface
Parameters:
- `NOP`, 32'h00000013, instruction word injected into a squashed slot (`addi x0,x0,0`).
- `CNT_W`, 32, width of the optional performance counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_X`  in  32  instruction in the X latch.
- `inst_W`  in  32  instruction in the W latch.
- `br_taken_X`  in  1  X-stage control resolved a taken branch, JAL or JALR this cycle.
- `pc_F_sel`  out  1  1 selects `alu_X` as next PC; 0 selects PC+4.
- `pc_en`  out  1  PC register load enable.
- `x_en`  out  1  F→X latch load enable.
- `w_en`  out  1  X→W latch load enable.
- `kill_X`  out  1  instruction in X is squashed; datapath forces `regWEn=0` and `dmem` write off for the X-stage instruction.
- `wb_valid`  out  1  write-back of `inst_W` is permitted this cycle (gates `regWEn` at the register file).
- `fwd_a`  out  1  1 makes the A operand take `wb_out` instead of `rs1_X`.
- `fwd_b`  out  1  1 makes the B/rs2 operand take `wb_out` instead of `rs2_X`.
- `stall_cnt`  out  CNT_W  cycles spent in LOAD_WAIT.
- `flush_cnt`  out  CNT_W  instructions squashed.

## Operation
Decode rules:
- rd(W) = `inst_W[11:7]`, valid only if the opcode is not STORE (0100011) or BRANCH (1100011).
- rs1(X) is used unless the opcode is LUI, AUIPC or JAL.
- rs2(X) is used only for OP, STORE and BRANCH.
- Register x0 is never a hazard source.
- `is_load_W` = opcode(W) == 0000011.

Hazard: `raw_a` = rs1 is used, rs1 != 0, rd(W) is valid, and rs1 == rd(W). `raw_b` is the same test for rs2.

FSM states: RUN, LOAD_WAIT.
- **RUN**
  - If `!kill_X` and `is_load_W` and (`raw_a`|`raw_b`), go to LOAD_WAIT.
  - In that cycle: `pc_en=x_en=w_en=0`, `wb_valid=0`, `pc_F_sel=0`, `fwd_a=fwd_b=0`.
  - Otherwise all enables are 1, `wb_valid=1`, `fwd_a=raw_a&!kill_X`, `fwd_b=raw_b&!kill_X`.
- **LOAD_WAIT** (exactly one cycle)
  - The load data is valid on `wb_out`.
  - All enables are 1, `wb_valid=1`, forwarding is per `raw_a`/`raw_b`.
  - Always returns to RUN.

Branch handling:
- `pc_F_sel = br_taken_X & !kill_X & !stall`, where stall is the RUN→LOAD_WAIT decision cycle.
- `kill_X` is registered: the next value is `pc_F_sel` (the wrong-path PC+4 instruction is in X next cycle).
- While `kill_X=1`, the X instruction cannot branch, stall, or request forwarding.
- It still advances into W; the datapath replaces the W-latch instruction with `NOP`, so `inst_W` of a squashed slot reads NOP.

A non-load in W never stalls; its result is forwarded via `wb_out` in the same cycle it is written.

## Timing
- Reset (rst=1 at an edge):
  - state=RUN.
  - `kill_X=1`, which squashes the undefined X-latch content in the first cycle.
  - Counters = 0.
  - Combinational outputs follow from these states.
- `rst` asserted mid-LOAD_WAIT: next state is RUN and the pending load write is abandoned.
- Branch penalty: 1 cycle (one squashed slot).
- Load-use penalty: 1 cycle.
- Load-use and taken branch in the same cycle: the stall wins and the branch is re-evaluated in LOAD_WAIT with forwarded data.
- Back-to-back taken branch: impossible to chain, because the second is killed.
- `pc_F_sel`, `pc_en`, `x_en`, `w_en`, `fwd_*` and `wb_valid` are combinational from state, `kill_X`, `inst_X`, `inst_W` and `br_taken_X`; there are no combinational paths from `clk`.
- Counters wrap modulo 2^CNT_W.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` increments once per LOAD_WAIT cycle.
  - `flush_cnt` increments once per cycle with `kill_X=1` after the first post-reset cycle.
- `HAZARD_PERF_CNT_EN` undefined:
  - No counter registers.
  - `stall_cnt`/`flush_cnt` are tied to 0.
  - All other behaviour is identical.

## Test plan
- **Reset:** rst=1 for 2 cycles, then 0 → first cycle `kill_X=1`, `pc_en=1`, `pc_F_sel=0`; second cycle `kill_X=0`.
- **ALU forward:** W=`addi x5,x0,7`, X=`add x6,x5,x5` → `fwd_a=fwd_b=1`, no stall, `wb_valid=1`. Same sequence with rd=x0 → `fwd_a=fwd_b=0`.
- **Load-use:** W=`lw x7,0(x1)`, X=`sw x7,4(x2)` → one cycle with `pc_en=x_en=w_en=0`, `wb_valid=0`, `fwd_b=0`; then LOAD_WAIT with `fwd_b=1`, `wb_valid=1`; `stall_cnt`=1.
- **Taken branch:** X=`beq` with `br_taken_X=1` → `pc_F_sel=1`; next cycle `kill_X=1`, and a `br_taken_X=1` driven during that cycle yields `pc_F_sel=0`; `flush_cnt`=1.
- **Branch depending on load:** W=`lw x3`, X=`bne x3,x4` with `br_taken_X=1` → `pc_F_sel=0` in the stall cycle, then `pc_F_sel=1` in LOAD_WAIT.
- **Reset mid-stall:** enter LOAD_WAIT and assert rst → next cycle state=RUN, `kill_X=1`, counters 0.
